// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch slot in, redirect from execute, head entry out to decode.
// The master side is the pipeline environment; the queue itself sits on the slave side.
interface fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            inst_v_i;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] inst_i;
   logic            pc_v_x;
   logic            stall_f;
   logic            inst_v_d;
   logic            ready_d;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] inst_d;
   logic            misalign_d;

   modport master (
      output inst_v_i, pc_i, inst_i, pc_v_x, ready_d,
      input  stall_f, inst_v_d, pc_d, inst_d, misalign_d
   );

   modport slave (
      input  inst_v_i, pc_i, inst_i, pc_v_x, ready_d,
      output stall_f, inst_v_d, pc_d, inst_d, misalign_d
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of {pc, inst, misalign}
// with a redirect flush, an almost-full stall to fetch and a sticky overflow flag.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_queue_if.slave  fq,
   output logic          overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 1);

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [XLEN-1:0] inst_mem [DEPTH];
   logic [DEPTH-1:0] mis_mem;

   logic full;
   logic push;
   logic pop;
   logic drop;

   assign full = (count == FULL_CNT);
   assign pop  = fq.inst_v_d & fq.ready_d & ~fq.pc_v_x;
   // A full queue still accepts a word when the head leaves in the same cycle.
   assign push = fq.inst_v_i & ~fq.pc_v_x & (~full | pop);
   assign drop = fq.inst_v_i & ~fq.pc_v_x & full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (drop)
            overflow <= 1'b1;
         if (fq.pc_v_x) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
         mis_mem <= '0;
      end else if (push) begin
         pc_mem[wr_ptr]   <= fq.pc_i;
         inst_mem[wr_ptr] <= fq.inst_i;
         mis_mem[wr_ptr]  <= (fq.pc_i[1:0] != 2'b00);
      end
   end

   // Head and stall are pure functions of registered state; nothing from inputs leaks through.
   assign fq.inst_v_d   = (count != '0);
   assign fq.pc_d       = pc_mem[rd_ptr];
   assign fq.inst_d     = inst_mem[rd_ptr];
   assign fq.misalign_d = mis_mem[rd_ptr];
   assign fq.stall_f    = (count >= STALL_CNT);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a table of per-cycle inputs and expected head/status,
// plus hand-written reset sequences.
module tb_fetch_queue;
   localparam int XLEN = 32;

   logic clk;
   logic reset_n;
   logic overflow;

   fetch_queue_if #(.XLEN(XLEN)) fq ();

   fetch_queue #(.DEPTH(4), .XLEN(XLEN)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .fq       (fq.slave),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        rdy;
      logic        fl;
      logic        e_v;
      logic [31:0] e_pc;
      logic        e_mis;
      logic        e_stall;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[30];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {~pc[15:0], pc[15:0]} ^ 32'h1357_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
      fq.inst_v_i = v;
      fq.pc_i     = pc;
      fq.inst_i   = inst_of(pc);
      fq.ready_d  = rdy;
      fq.pc_v_x   = fl;
   endtask

   initial begin
      // Each row: inputs for this cycle, and outputs expected in this cycle before its edge.
      //              v  pc           rdy fl  e_v e_pc         mis stl ovf
      vecs[0]  = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 32'h004, 1'b1, 1'b0, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 32'h008, 1'b1, 1'b0, 1'b1, 32'h004, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h008, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 32'h010, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 32'h014, 1'b0, 1'b0, 1'b1, 32'h010, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 32'h018, 1'b0, 1'b0, 1'b1, 32'h010, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 32'h01C, 1'b0, 1'b0, 1'b1, 32'h010, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 32'h020, 1'b0, 1'b0, 1'b1, 32'h010, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 32'h024, 1'b1, 1'b0, 1'b1, 32'h010, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h014, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 32'h018, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 32'h018, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 32'h030, 1'b1, 1'b1, 1'b1, 32'h018, 1'b0, 1'b1, 1'b1};
      vecs[15] = '{1'b1, 32'h040, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1};
      vecs[16] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 32'h040, 1'b0, 1'b0, 1'b1};
      vecs[17] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h040, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{1'b1, 32'h102, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1};
      vecs[19] = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 32'h102, 1'b1, 1'b0, 1'b1};
      vecs[20] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1};
      vecs[21] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1};
      vecs[22] = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b1};
      vecs[23] = '{1'b1, 32'h204, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1};
      vecs[24] = '{1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1};
      vecs[25] = '{1'b1, 32'h20C, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1};
      vecs[26] = '{1'b1, 32'h210, 1'b0, 1'b0, 1'b1, 32'h208, 1'b0, 1'b0, 1'b1};
      vecs[27] = '{1'b1, 32'h214, 1'b1, 1'b0, 1'b1, 32'h208, 1'b0, 1'b1, 1'b1};
      vecs[28] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h20C, 1'b0, 1'b1, 1'b1};
      vecs[29] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 32'h210, 1'b0, 1'b0, 1'b1};

      drive(1'b0, 32'h0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #12;
      check("rst_inst_v_d", 32'(fq.inst_v_d), 32'd0);
      check("rst_pc_d", fq.pc_d, 32'd0);
      check("rst_inst_d", fq.inst_d, 32'd0);
      check("rst_misalign_d", 32'(fq.misalign_d), 32'd0);
      check("rst_stall_f", 32'(fq.stall_f), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
         #1;
         check($sformatf("v%0d_inst_v_d", i), 32'(fq.inst_v_d), 32'(vecs[i].e_v));
         check($sformatf("v%0d_stall_f", i), 32'(fq.stall_f), 32'(vecs[i].e_stall));
         check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
         if (vecs[i].e_v) begin
            check($sformatf("v%0d_pc_d", i), fq.pc_d, vecs[i].e_pc);
            check($sformatf("v%0d_inst_d", i), fq.inst_d, inst_of(vecs[i].e_pc));
            check($sformatf("v%0d_misalign_d", i), 32'(fq.misalign_d), 32'(vecs[i].e_mis));
         end
      end

      // Mid-stream asynchronous reset: two entries queued, reset lands between edges.
      @(negedge clk);
      drive(1'b1, 32'h300, 1'b0, 1'b0);
      #1;
      check("pre_rst_inst_v_d", 32'(fq.inst_v_d), 32'd1);
      check("pre_rst_pc_d", fq.pc_d, 32'h210);
      reset_n = 1'b0;
      #1;
      check("async_rst_inst_v_d", 32'(fq.inst_v_d), 32'd0);
      check("async_rst_pc_d", fq.pc_d, 32'd0);
      check("async_rst_inst_d", fq.inst_d, 32'd0);
      check("async_rst_stall_f", 32'(fq.stall_f), 32'd0);
      check("async_rst_overflow", 32'(overflow), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1, 32'h400, 1'b0, 1'b0);
      #1;
      check("post_rst_empty", 32'(fq.inst_v_d), 32'd0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("post_rst_push_v", 32'(fq.inst_v_d), 32'd1);
      check("post_rst_push_pc", fq.pc_d, 32'h400);
      check("post_rst_push_inst", fq.inst_d, inst_of(32'h400));
      @(negedge clk);
      #1;
      check("post_rst_hold_pc", fq.pc_d, 32'h400);
      check("post_rst_ovf", 32'(overflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
